// File: rtl/lab5_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : lab5_fetch_stage
// Brief   : Instruction fetch: owns the PC, drives the ROM address, and fills
//           the IF/ID register (boot delay, stall, redirect/flush, halt).
// Revision: 1.0 - initial release
// ============================================================================
module lab5_fetch_stage #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter int         BOOT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_q,
    input  logic        stall,
    input  logic        redirect,
    input  logic [7:0]  redirect_addr,
    input  logic        halt,
    output logic [15:0] ifid_instr,
    output logic [7:0]  ifid_pc,
    output logic [7:0]  ifid_pcp2,
    output logic        ifid_valid,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_BOOT = 2'b00,
        S_RUN  = 2'b01,
        S_HALT = 2'b10
    } state_t;

    localparam logic [3:0] c_BOOT_LAST = 4'(BOOT_CYCLES - 1);
    localparam logic [7:0] c_PC_INIT   = {RESET_PC[7:1], 1'b0};

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [7:0]  r_pc, w_pc_nxt;
    logic [15:0] r_instr, w_instr_nxt;
    logic [7:0]  r_ipc, w_ipc_nxt;
    logic [7:0]  r_ipcp2, w_ipcp2_nxt;
    logic        r_valid, w_valid_nxt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_BOOT;
            r_cnt   <= 4'd0;
            r_pc    <= c_PC_INIT;
            r_instr <= 16'h0000;
            r_ipc   <= 8'h00;
            r_ipcp2 <= 8'h00;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_ipc   <= w_ipc_nxt;
            r_ipcp2 <= w_ipcp2_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_ipc_nxt   = r_ipc;
        w_ipcp2_nxt = r_ipcp2;
        w_valid_nxt = r_valid;
        case (r_state)
            S_BOOT: begin
                w_cnt_nxt = r_cnt + 4'd1;
                if (r_cnt == c_BOOT_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Redirect wins even over stall so the wrong-path word is flushed.
                if (redirect) begin
                    w_pc_nxt    = redirect_addr & 8'hFE;
                    w_valid_nxt = 1'b0;
                    w_instr_nxt = 16'h0000;
                end else if (halt) begin
                    w_state_nxt = S_HALT;
                    w_valid_nxt = 1'b0;
                end else if (!stall) begin
                    w_instr_nxt = imem_q;
                    w_ipc_nxt   = r_pc;
                    w_ipcp2_nxt = r_pc + 8'd2;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = r_pc + 8'd2;
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign imem_addr  = r_pc;
    assign ifid_instr = r_instr;
    assign ifid_pc    = r_ipc;
    assign ifid_pcp2  = r_ipcp2;
    assign ifid_valid = r_valid;
    assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_lab5_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_lab5_fetch_stage
// Brief   : Directed + randomized bench for lab5_fetch_stage against a
//           behavioural fetch model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lab5_fetch_stage;

    localparam int c_BOOT = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [7:0]  imem_addr;
    logic [15:0] imem_q;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic        halt;
    logic [15:0] ifid_instr;
    logic [7:0]  ifid_pc;
    logic [7:0]  ifid_pcp2;
    logic        ifid_valid;
    logic [1:0]  state_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: mode 0 boot, 1 run, 2 halt.
    int          m_mode, m_cnt, m_pc, m_ipc, m_ipcp2;
    logic [15:0] m_instr;
    bit          m_valid;

    always #5 CLK = ~CLK;

    assign imem_q = 16'hA000 + 16'(imem_addr >> 1);

    lab5_fetch_stage #(
        .RESET_PC   (8'h00),
        .BOOT_CYCLES(c_BOOT)
    ) u_dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .imem_addr    (imem_addr),
        .imem_q       (imem_q),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_addr(redirect_addr),
        .halt         (halt),
        .ifid_instr   (ifid_instr),
        .ifid_pc      (ifid_pc),
        .ifid_pcp2    (ifid_pcp2),
        .ifid_valid   (ifid_valid),
        .state_o      (state_o)
    );

    function automatic logic [15:0] rom(int a);
        return 16'hA000 + 16'(a / 2);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_edge();
        if (RESET) begin
            m_mode = 0; m_cnt = 0; m_pc = 0;
            m_instr = 16'h0; m_ipc = 0; m_ipcp2 = 0; m_valid = 0;
        end else if (m_mode == 0) begin
            if (m_cnt == c_BOOT - 1) m_mode = 1;
            m_cnt++;
        end else if (m_mode == 1) begin
            if (redirect) begin
                m_pc = (redirect_addr / 2) * 2;
                m_valid = 0;
                m_instr = 16'h0;
            end else if (halt) begin
                m_mode = 2;
                m_valid = 0;
            end else if (!stall) begin
                m_instr = rom(m_pc);
                m_ipc   = m_pc;
                m_ipcp2 = (m_pc + 2) % 256;
                m_valid = 1;
                m_pc    = (m_pc + 2) % 256;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        check("imem_addr",  32'(imem_addr),  32'(m_pc));
        check("ifid_instr", 32'(ifid_instr), 32'(m_instr));
        check("ifid_pc",    32'(ifid_pc),    32'(m_ipc));
        check("ifid_pcp2",  32'(ifid_pcp2),  32'(m_ipcp2));
        check("ifid_valid", 32'(ifid_valid), 32'(m_valid));
        check("state_o",    32'(state_o),    32'(m_mode));
    endtask

    task automatic set_in(bit rst, bit st, bit rd, logic [7:0] ra, bit hl);
        RESET = rst; stall = st; redirect = rd; redirect_addr = ra; halt = hl;
    endtask

    initial begin
        m_mode = 0; m_cnt = 0; m_pc = 0; m_ipc = 0; m_ipcp2 = 0;
        m_instr = 16'h0; m_valid = 0;
        set_in(1, 0, 0, 8'h00, 0);

        // Boot and sequential fetch
        tick(); tick();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_valid", 32'(ifid_valid), 32'd0);
        set_in(0, 0, 0, 8'h00, 0);
        tick(); check("boot_valid0", 32'(ifid_valid), 32'd0);
        tick(); check("boot_valid1", 32'(ifid_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("seq_instr", 32'(ifid_instr), 32'(16'hA000 + 16'(i)));
            check("seq_pc",    32'(ifid_pc),    32'(2 * i));
            check("seq_pcp2",  32'(ifid_pcp2),  32'(2 * i + 2));
        end

        // Stall while ifid_pc = 06
        tick();
        set_in(0, 1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr",  32'(imem_addr),  32'h08);
            check("stall_instr", 32'(ifid_instr), 32'hA003);
        end
        set_in(0, 0, 0, 8'h00, 0);
        tick();
        check("post_stall_instr", 32'(ifid_instr), 32'hA004);
        check("post_stall_pc",    32'(ifid_pc),    32'h08);

        // Redirect with simultaneous stall
        set_in(0, 1, 1, 8'h51, 0);
        tick();
        check("rdst_pc",    32'(imem_addr),  32'h50);
        check("rdst_valid", 32'(ifid_valid), 32'd0);
        check("rdst_instr", 32'(ifid_instr), 32'h0);
        set_in(0, 0, 0, 8'h00, 0);
        tick();
        check("rd_instr", 32'(ifid_instr), 32'hA028);
        check("rd_pc",    32'(ifid_pc),    32'h50);

        // Wrap-around
        set_in(0, 0, 1, 8'hFC, 0);
        tick();
        set_in(0, 0, 0, 8'h00, 0);
        tick(); check("wrap_pc0", 32'(ifid_pc), 32'hFC);
        tick(); check("wrap_pc1", 32'(ifid_pc), 32'hFE);
        check("wrap_pcp2", 32'(ifid_pcp2), 32'h00);
        tick(); check("wrap_pc2", 32'(ifid_pc), 32'h00);

        // Halt at ifid_pc = 10, then random noise on the other inputs
        set_in(0, 0, 1, 8'h10, 0);
        tick();
        set_in(0, 0, 0, 8'h00, 0);
        tick();
        set_in(0, 0, 0, 8'h00, 1);
        tick();
        for (int i = 0; i < 6; i++) begin
            set_in(0, 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
            tick();
            check("halt_state", 32'(state_o),    32'h2);
            check("halt_addr",  32'(imem_addr),  32'h12);
            check("halt_valid", 32'(ifid_valid), 32'd0);
        end
        set_in(1, 0, 0, 8'h00, 0);
        tick();
        check("halt_rst_state", 32'(state_o),   32'h0);
        check("halt_rst_addr",  32'(imem_addr), 32'h00);

        // Reset mid-run at pc = 3A with a valid word held
        set_in(0, 0, 1, 8'h36, 1);
        tick(); tick();
        tick();
        set_in(0, 0, 0, 8'h00, 0);
        tick(); tick();
        check("pre_rst_pc",    32'(imem_addr),  32'h3A);
        check("pre_rst_valid", 32'(ifid_valid), 32'd1);
        set_in(1, 0, 0, 8'h00, 0);
        tick();
        check("mid_rst_pc",    32'(imem_addr),  32'h00);
        check("mid_rst_valid", 32'(ifid_valid), 32'd0);
        check("mid_rst_state", 32'(state_o),    32'h0);
        set_in(0, 0, 0, 8'h00, 0);
        tick(); check("reboot_valid0", 32'(ifid_valid), 32'd0);
        tick(); check("reboot_valid1", 32'(ifid_valid), 32'd0);
        tick(); check("reboot_instr",  32'(ifid_instr), 32'hA000);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            set_in(($urandom % 100) < ((m_mode == 2) ? 15 : 2),
                   ($urandom % 4) == 0,
                   ($urandom % 8) == 0,
                   8'($urandom),
                   ($urandom % 50) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
